// File: rtl/rca_operand_feeder.sv
// Clocked front/back-end for a combinational ripple-carry adder: queues operand triples,
// holds them on the adder for a settle window, then registers sum/carry behind valid/ready.
//   state    | meaning
//   S_IDLE   | no operands on the adder, waiting for the FIFO to go non-empty
//   S_SETTLE | operands driven, counting down the ripple settle window
//   S_HOLD   | result captured and presented, waiting for out_ready
module rca_operand_feeder #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 2 * WIDTH + 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [EW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic           r_cin;
  logic [WIDTH-1:0] r_out_sum;
  logic           r_out_carry;
  logic           r_out_valid;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_capture;
  logic           w_release;
  logic [EW-1:0]  w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_a, in_b, in_cin};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Emptiness is judged before the edge, so a push on a release edge waits for IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CW'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_pop) begin
        {r_a, r_b, r_cin} <= w_head;
        r_cnt             <= CW'(SETTLE_CYCLES);
      end else if (r_state == S_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_sum   <= sum;
        r_out_carry <= carry;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign cin       = r_cin;
  assign out_sum   = r_out_sum;
  assign out_carry = r_out_carry;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rca_operand_feeder.sv
// Scoreboarded bench for rca_operand_feeder: directed timing scenarios plus random traffic,
// with a behavioural adder and a second instance built with a one-cycle settle window.
module tb_rca_operand_feeder;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_cin, cin, carry, out_valid, out_ready, out_carry;
  logic [W-1:0] in_a, in_b, a, b, sum, out_sum;

  logic         s1_in_valid, s1_in_ready, s1_in_cin, s1_cin, s1_carry;
  logic         s1_out_valid, s1_out_ready, s1_out_carry;
  logic [W-1:0] s1_in_a, s1_in_b, s1_a, s1_b, s1_sum, s1_out_sum;

  assign {carry, sum}       = a + b + cin;
  assign {s1_carry, s1_sum} = s1_a + s1_b + s1_cin;

  rca_operand_feeder #(.WIDTH(W), .SETTLE_CYCLES(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry)
  );

  rca_operand_feeder #(.WIDTH(W), .SETTLE_CYCLES(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_a(s1_in_a), .in_b(s1_in_b),
    .in_cin(s1_in_cin),
    .a(s1_a), .b(s1_b), .cin(s1_cin), .sum(s1_sum), .carry(s1_carry),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum),
    .out_carry(s1_out_carry)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  logic [W:0] exp_q[$];
  logic [W:0] sb_e;
  int rises[$];
  logic [W:0] s1_got[$];
  logic [W:0] s1_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t % (1 << (W+1)));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected results queued on accepted pushes, compared on accepted results.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0d required=none", {out_carry, out_sum});
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_result", int'({out_carry, out_sum}), int'(sb_e));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(in_a, in_b, in_cin));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, bad, k;
    logic [W-1:0] h_sum, h_a, h_b;
    logic [W-1:0] t2a[3], t2b[3];
    logic         t2c[3];
    logic [W-1:0] sa, sb;
    logic         sc;
    t2a = '{4'hF, 4'h3, 4'h7};
    t2b = '{4'h1, 4'h4, 4'h7};
    t2c = '{1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    s1_in_valid = 0; s1_in_a = 0; s1_in_b = 0; s1_in_cin = 0; s1_out_ready = 0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_cin", cin, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", {out_carry, out_sum}, 0);
    rst = 1'b0;

    // 1: single operation latency
    in_valid = 1; in_a = 4'h9; in_b = 4'h8; in_cin = 1; out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    chk("t1_a", a, 9); chk("t1_b", b, 8); chk("t1_cin", cin, 1);
    chk("t1_ov_e1", out_valid, 0);
    tick();
    chk("t1_ov_e2", out_valid, 0);
    tick();
    chk("t1_ov_e3", out_valid, 1);
    chk("t1_sum", out_sum, 2);
    chk("t1_carry", out_carry, 1);
    tick();
    chk("t1_ov_e4", out_valid, 0);

    // 2: streaming, pulses spaced SETTLE+1
    rises.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = t2a[i]; in_b = t2b[i]; in_cin = t2c[i];
      tick();
      if (out_valid) rises.push_back(cyc);
    end
    in_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) rises.push_back(cyc);
    end
    chk("t2_pulses", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("t2_gap0", rises[1] - rises[0], 3);
      chk("t2_gap1", rises[2] - rises[1], 3);
    end

    // 3: back-pressure fills FIFO, then drain
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_a = W'(i + 1); in_b = W'(2 * i); in_cin = i[0];
      tick();
    end
    in_valid = 0;
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_ov", out_valid, 1);
    chk("t3_a_first", a, 1);
    h_sum = out_sum; h_a = a; h_b = b;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_sum !== h_sum || a !== h_a || b !== h_b || out_valid !== 1'b1) bad++;
    end
    chk("t3_stable", bad, 0);
    n0 = n_out;
    out_ready = 1;
    k = 0;
    while (k < 100 && !((n_out - n0) == 5 && !out_valid)) begin
      tick();
      k++;
    end
    chk("t3_drained", n_out - n0, 5);
    chk("t3_in_ready", in_ready, 1);

    // 4: reset during SETTLE with two queued entries
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = W'(4 + i); in_b = W'(3); in_cin = 1;
      tick();
    end
    in_valid = 0;
    rst = 1;
    #1;
    chk("t4_ov", out_valid, 0);
    chk("t4_ab", {a, b}, 0);
    chk("t4_cin", cin, 0);
    chk("t4_in_ready", in_ready, 1);
    tick();
    rst = 0;
    n0 = n_out;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) bad++;
    end
    chk("t4_quiet", bad, 0);
    chk("t4_no_out", n_out - n0, 0);

    // 5: push coinciding with HOLD release on empty FIFO
    out_ready = 0;
    in_valid = 1; in_a = 4'h5; in_b = 4'h6; in_cin = 1;
    tick();
    in_valid = 0;
    k = 0;
    while (k < 10 && !out_valid) begin
      tick();
      k++;
    end
    chk("t5_hold", out_valid, 1);
    chk("t5_hold_sum", {out_carry, out_sum}, int'(ref_add(4'h5, 4'h6, 1'b1)));
    out_ready = 1;
    in_valid = 1; in_a = 0; in_b = 0; in_cin = 0;
    tick();
    in_valid = 0;
    chk("t5_idle_ov", out_valid, 0);
    chk("t5_a_held", a, 5);
    tick();
    chk("t5_a_pop", a, 0);
    tick();
    chk("t5_ov_e2", out_valid, 0);
    tick();
    chk("t5_ov_e3", out_valid, 1);
    chk("t5_res", {out_carry, out_sum}, 0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    k = 0;
    while (k < 200 && !(exp_q.size() == 0 && !out_valid)) begin
      tick();
      k++;
    end
    chk("rand_drain", exp_q.size(), 0);

    // 6: SETTLE_CYCLES=1 instance
    s1_out_ready = 1;
    s1_in_valid = 1; s1_in_a = 4'hA; s1_in_b = 4'h5; s1_in_cin = 1;
    tick();
    s1_in_valid = 0;
    tick();
    chk("t6_a", s1_a, 10);
    chk("t6_ov_e1", s1_out_valid, 0);
    tick();
    chk("t6_ov_e2", s1_out_valid, 1);
    chk("t6_res", {s1_out_carry, s1_out_sum}, int'(ref_add(4'hA, 4'h5, 1'b1)));
    tick();
    chk("t6_ov_e3", s1_out_valid, 0);
    rises.delete();
    s1_got.delete();
    s1_exp.delete();
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        sa = W'($urandom); sb = W'($urandom); sc = 1'($urandom);
        s1_in_valid = 1; s1_in_a = sa; s1_in_b = sb; s1_in_cin = sc;
        s1_exp.push_back(ref_add(sa, sb, sc));
      end else begin
        s1_in_valid = 0;
      end
      tick();
      if (s1_out_valid) begin
        rises.push_back(cyc);
        s1_got.push_back({s1_out_carry, s1_out_sum});
      end
    end
    chk("t6_count", s1_got.size(), 4);
    if (s1_got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t6_stream_res", int'(s1_got[i]), int'(s1_exp[i]));
      for (int i = 1; i < 4; i++) chk("t6_gap", rises[i] - rises[i-1], 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_operand_feeder.md
Name: rca_operand_feeder

Overview:
Sequential front/back-end stage wrapped around the combinational ripple-carry adder (ports a, b, cin, sum, carry).
- Accepts operand triples through a valid/ready input FIFO.
- Drives each triple onto the adder and holds it stable for a programmable settle window covering the ripple delay.
- Captures sum/carry into a registered result with a valid/ready output handshake.
- Lets the testbench and system logic run the adder at a clocked, back-pressured rate.

Parameters:
- WIDTH, 4, operand/sum width; must match the adder.
- SETTLE_CYCLES, 2, clock cycles operands are held before sum/carry are sampled; legal range 1..15.
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand triple present.
- in_ready  output  1  FIFO can accept; equals !fifo_full.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- a  output  WIDTH  to adder a.
- b  output  WIDTH  to adder b.
- cin  output  1  to adder cin.
- sum  input  WIDTH  from adder sum.
- carry  input  1  from adder carry.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  captured sum.
- out_carry  output  1  captured carry.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (async, immediate):
  - FIFO emptied, state IDLE, settle counter 0.
  - a, b, cin, out_sum, out_carry = 0; out_valid = 0.
  - in_ready = 1 as soon as the FIFO is empty (combinational).
  - Reset mid-operation discards in-flight and queued operands; no result is emitted after release.
- FIFO push: on an edge with in_valid && in_ready.
  - in_ready = !full only. A pop in the same cycle does not open a slot when full.
  - Push and pop in the same edge when not full both occur; count is unchanged.
- FSM:
  - IDLE: if the FIFO is non-empty at an edge → pop head into registered a/b/cin, load counter = SETTLE_CYCLES, go SETTLE.
  - SETTLE: counter decrements each edge. On the edge where counter == 1:
    - out_sum ← sum, out_carry ← carry, out_valid ← 1.
    - Go HOLD.
  - HOLD: out_valid = 1; out_sum/out_carry stable.
    - On an edge with out_ready = 1: if the FIFO is non-empty at that edge, pop next triple, reload counter, go SETTLE (out_valid drops the same edge); otherwise go IDLE, out_valid ← 0.
    - With out_ready = 0: hold indefinitely.
- a/b/cin change only on a pop edge and are otherwise held, including in IDLE and HOLD.
- Latency: push at edge 0 into an empty FIFO in IDLE → pop at edge 1 → capture at edge 1+SETTLE_CYCLES (edge 3 at default).
- Throughput: with out_ready held high, one result per SETTLE_CYCLES+1 cycles.
- A push landing on the same edge as a HOLD release while the FIFO is empty is not popped that edge. It is popped from IDLE on the following edge.
- Arithmetic belongs to the adder. This block only samples it: sum is modulo 2^WIDTH, carry is bit WIDTH of a+b+cin.
- Results leave strictly in push order; none are dropped or duplicated.

Test Plan:
1. Reset, push a=9,b=8,cin=1 at edge 0, out_ready=1 → a/b/cin = 9/8/1 after edge 1; out_valid rises at edge 3 with out_sum=4'h2, out_carry=1; drops at edge 4.
2. Stream three triples (F,1,0), (3,4,1), (7,7,0) with out_ready=1 → results (0,1), (8,0), (E,0), in order, out_valid pulses spaced 3 cycles.
3. out_ready=0, push 5 triples back-to-back → first is captured and held; the next 4 fill the FIFO; in_ready low after the 5th push. out_sum and a/b stay stable for 10 cycles. Raising out_ready drains all 5 in order.
4. Assert rst during SETTLE with 2 queued entries → immediately out_valid=0, a/b/cin=0, in_ready=1; after release with no pushes, out_valid stays 0 for 10 cycles.
5. In HOLD with FIFO empty, out_ready=1 and push (0,0,0) on the same edge → IDLE at that edge, pop next edge, result (0,0) two edges later.
6. SETTLE_CYCLES=1 build: push (A,5,1) → result (0,1) at edge 2; streaming throughput one per 2 cycles.
